// File: rtl/aes_subbytes_seq.sv
// aes_subbytes_seq: multi-cycle AES SubBytes, LANES forward S-box lookups per cycle
package aes_gf_pkg;
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      p = y[i] ? p ^ t : p;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
endpackage

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  import aes_gf_pkg::*;
  logic [7:0] b;
  assign b = ginv(a);
  assign c = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  import aes_gf_pkg::*;
  assign c = ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
endmodule

module aes_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;
  state_t state, nxt_state;
  logic [4:0] cnt, nxt_cnt;
  logic [127:0] st, nxt_st, sub_st;
  logic [7:0] lane_in [LANES];
  logic [7:0] lane_out [LANES];
  logic [6:0] pos [LANES];
  // byte i lives at bit offset 8*(15-i), and 15-i is ~i in four bits
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign pos[g] = {~(cnt[3:0] + 4'(g)), 3'b000};
    assign lane_in[g] = st[pos[g] +: 8];
    sbox u_sbox (.a(lane_in[g]), .c(lane_out[g]));
  end
  always_comb begin
    sub_st = st;
    for (int l = 0; l < LANES; l++) sub_st[pos[l] +: 8] = lane_out[l];
  end
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_st = st;
    unique case (state)
      IDLE: if (in_valid) begin
        nxt_st = in_data;
        nxt_cnt = '0;
        nxt_state = SUB;
      end
      SUB: begin
        nxt_st = sub_st;
        nxt_cnt = cnt + 5'(LANES);
        nxt_state = (cnt + 5'(LANES) == 5'd16) ? HOLD : SUB;
      end
      HOLD: nxt_state = out_ready ? IDLE : HOLD;
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      st <= '0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      st <= nxt_st;
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  assign out_data = st;
endmodule

// File: tb/tb_aes_subbytes_seq.sv
// tb_aes_subbytes_seq: directed checks of aes_subbytes_seq at LANES=4, 1 and 16
module tb_aes_subbytes_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [127:0] in_data = '0;
  logic ir4, ov4, bz4, ir1, ov1, bz1, ir16, ov16, bz16;
  logic [127:0] od4, od1, od16, rt;
  int checks = 0, errors = 0;
  int lat4, lat1, lat16;
  logic [127:0] o4, o1, o16;
  localparam logic [127:0] KAT_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KAT_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SW_IN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SW_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] SB [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always #5 clk = ~clk;

  aes_subbytes_seq #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4));
  aes_subbytes_seq #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1));
  aes_subbytes_seq #(.LANES(16)) dut16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .in_data(in_data), .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .busy(bz16));
  for (genvar g = 0; g < 16; g++) begin : g_rt
    inv_sbox u_inv (.a(od4[127-8*g -: 8]), .c(rt[127-8*g -: 8]));
  end

  function automatic logic [7:0] gs(input logic [7:0] x);
    logic [127:0] row;
    row = SB[x[7:4]];
    return row[127-8*x[3:0] -: 8];
  endfunction

  function automatic logic [127:0] golden(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = gs(x[127-8*i -: 8]);
    return r;
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 40 && !(ir4 && ir1 && ir16); n++) begin @(posedge clk); #1; end
  endtask

  task automatic run_block(input logic [127:0] din);
    lat4 = 0; lat1 = 0; lat16 = 0;
    o4 = 'x; o1 = 'x; o16 = 'x;
    @(negedge clk); in_data = din; in_valid = 1;
    @(posedge clk); #1 in_valid = 0; in_data = ~din;
    for (int n = 1; n <= 20 && (lat4 == 0 || lat1 == 0 || lat16 == 0); n++) begin
      @(posedge clk); #1;
      if (ov4 && lat4 == 0) begin lat4 = n; o4 = od4; end
      if (ov1 && lat1 == 0) begin lat1 = n; o1 = od1; end
      if (ov16 && lat16 == 0) begin lat16 = n; o16 = od16; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", ov4); end
    checks++; if (bz4 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bz4); end
    checks++; if (od4 !== 128'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", od4); end
    checks++; if ({ir1, ir16, ov1, ov16} !== 4'b1100) begin errors++; $display("FAIL rst_lanes got %b exp 1100", {ir1, ir16, ov1, ov16}); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_kat();
    run_block(KAT_IN);
    checks++; if (o4 !== KAT_OUT) begin errors++; $display("FAIL kat_data got %h exp %h", o4, KAT_OUT); end
    checks++; if (lat4 !== 4) begin errors++; $display("FAIL kat_latency got %0d exp 4", lat4); end
    checks++; if (ir4 !== 1'b1 || bz4 !== 1'b0) begin errors++; $display("FAIL kat_idle got ready=%b busy=%b exp 1 0", ir4, bz4); end
    checks++; if (od4 !== KAT_OUT) begin errors++; $display("FAIL kat_retain got %h exp %h", od4, KAT_OUT); end
  endtask

  task automatic test_zero_ones();
    run_block(128'h0);
    checks++; if (o4 !== {16{8'h63}}) begin errors++; $display("FAIL zeros got %h exp %h", o4, {16{8'h63}}); end
    run_block({128{1'b1}});
    checks++; if (o4 !== {16{8'h16}}) begin errors++; $display("FAIL ones got %h exp %h", o4, {16{8'h16}}); end
  endtask

  task automatic test_param_sweep();
    run_block(SW_IN);
    checks++; if (o1 !== SW_OUT) begin errors++; $display("FAIL lanes1_data got %h exp %h", o1, SW_OUT); end
    checks++; if (lat1 !== 16) begin errors++; $display("FAIL lanes1_latency got %0d exp 16", lat1); end
    checks++; if (o16 !== SW_OUT) begin errors++; $display("FAIL lanes16_data got %h exp %h", o16, SW_OUT); end
    checks++; if (lat16 !== 1) begin errors++; $display("FAIL lanes16_latency got %0d exp 1", lat16); end
    checks++; if (o4 !== SW_OUT) begin errors++; $display("FAIL lanes4_data got %h exp %h", o4, SW_OUT); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held, second;
    int n;
    second = 128'hdeadbeef0123456789abcdeffedcba98;
    out_ready = 0;
    @(negedge clk); in_data = SW_IN; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    n = 0;
    while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", n); end
    held = od4;
    checks++; if (held !== SW_OUT) begin errors++; $display("FAIL bp_data got %h exp %h", held, SW_OUT); end
    in_valid = 1; in_data = second;
    repeat (10) begin
      @(posedge clk); #1;
      checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", ov4); end
      checks++; if (od4 !== held) begin errors++; $display("FAIL bp_stable got %h exp %h", od4, held); end
      checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", ir4); end
    end
    out_ready = 1;
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL bp_handshake got valid=%b ready=%b exp 0 1", ov4, ir4); end
    @(posedge clk); #1 in_valid = 0;
    checks++; if (bz4 !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy=%b exp 1", bz4); end
    n = 0;
    while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (od4 !== golden(second)) begin errors++; $display("FAIL bp_second got %h exp %h", od4, golden(second)); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); in_data = KAT_IN; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", ov4); end
    checks++; if (od4 !== 128'h0) begin errors++; $display("FAIL mid_out_data got %h exp 0", od4); end
    checks++; if (ir4 !== 1'b1 || bz4 !== 1'b0) begin errors++; $display("FAIL mid_in_ready got ready=%b busy=%b exp 1 0", ir4, bz4); end
    rst = 0;
    run_block(KAT_IN);
    checks++; if (o4 !== KAT_OUT) begin errors++; $display("FAIL mid_recover got %h exp %h", o4, KAT_OUT); end
    checks++; if (lat4 !== 4) begin errors++; $display("FAIL mid_latency got %0d exp 4", lat4); end
  endtask

  task automatic test_exhaustive();
    logic [127:0] b;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) b[127-8*i -: 8] = 8'(16 * k + i);
      run_block(b);
      checks++; if (o4 !== golden(b)) begin errors++; $display("FAIL exh_%0d got %h exp %h", k, o4, golden(b)); end
      checks++; if (rt !== b) begin errors++; $display("FAIL exh_roundtrip_%0d got %h exp %h", k, rt, b); end
      checks++; if (o16 !== golden(b)) begin errors++; $display("FAIL exh16_%0d got %h exp %h", k, o16, golden(b)); end
    end
  endtask

  initial begin
    test_reset();
    test_kat();
    test_zero_ones();
    test_param_sweep();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
